// File: rtl/choreo_pkg.sv
// -----------------------------------------------------------------------------
// choreo_pkg
// Shared types and helpers for the choreography sequencer.
//   state_t   : playback FSM states
//   gap_t     : 2-bit per-step gap code
//   gap_ticks : maps a gap code onto one of four tick counts
// -----------------------------------------------------------------------------
package choreo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] gap_t;

    // The tick table is owned by the instantiating module's parameters, so the
    // four entries are passed in rather than fixed here.
    function automatic int gap_ticks(input gap_t code,
                                     input int g0, input int g1,
                                     input int g2, input int g3);
        case (code)
            2'd0:    return g0;
            2'd1:    return g1;
            2'd2:    return g2;
            default: return g3;
        endcase
    endfunction

endpackage

// File: rtl/choreography_sequencer_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Loadable down-counter that times the gap between two pattern steps.
//   clock, resetn : clock and synchronous active-low reset
//   load          : start a new gap; load_val is the count that ends in expire
//   load_val      : ticks minus one until expiry
//   clear         : abandon the running gap (highest priority after reset)
//   hold          : freeze the count; also masks expire
//   expire        : high in the cycle the count sits at zero and is not held
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int CW = 30
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          clear,
    input  logic          hold,
    output logic          expire
);

    logic [CW-1:0] count;
    logic          active;

    // Combinational so the owner can react (reload or finish) on the same edge.
    assign expire = active && !hold && (count == '0);

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments for all state so every register
        // samples pre-edge values, independent of statement order.
        if (!resetn) begin
            count  <= '0;
            active <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            active <= 1'b1;
        end else if (expire) begin
            active <= 1'b0;
        end else if (active && !hold) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/choreography_sequencer.sv
// -----------------------------------------------------------------------------
// choreography_sequencer
// Plays a loadable pattern of lane-spawn steps. Each stored step is
// {mask[LANES-1:0], gap[1:0]}; the gap code picks the delay to the next step.
//   clock, resetn      : clock and synchronous active-low reset
//   start, stop, pause : playback control (pause is a level)
//   loop_en, len       : wrap mode and pattern length, sampled at start
//   wr_en/addr/mask/gap: pattern write port, honoured only while idle
//   spawn              : one-cycle lane pulses for the emitted step
//   step_idx           : index of the last emitted step
//   busy               : playback in progress
//   done               : one-cycle pulse at one-shot completion or on stop
//   loop_count         : completed loops, saturating at 255
// -----------------------------------------------------------------------------
module choreography_sequencer
    import choreo_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int STEPS = 128,
    parameter  int GAP0  = 10000000,
    parameter  int GAP1  = 6000000,
    parameter  int GAP2  = 20000000,
    parameter  int GAP3  = 9000000,
    parameter  int CW    = 30,
    localparam int AW    = $clog2(STEPS),
    localparam int LW    = $clog2(STEPS + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [LW-1:0]    len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_mask,
    input  logic [1:0]       wr_gap,
    output logic [LANES-1:0] spawn,
    output logic [AW-1:0]    step_idx,
    output logic             busy,
    output logic             done,
    output logic [7:0]       loop_count
);

    localparam int DW = LANES + 2;

    logic [DW-1:0] mem [STEPS];
    logic [DW-1:0] rdata;      // holds the next step until it is emitted
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    state_t        state;
    logic [AW-1:0] cur_addr;   // address of the step sitting in rdata
    logic [LW-1:0] len_q;
    logic          loop_q;
    logic          final_q;    // last step of a one-shot run is playing

    logic          start_ok;
    logic          wr_ok;
    logic [LW-1:0] len_eff;
    logic          is_last;
    logic [AW-1:0] next_addr;
    logic          emit;
    logic          finish;
    logic          t_expire;
    logic [CW-1:0] t_val;

    assign len_eff  = (len > LW'(STEPS)) ? LW'(STEPS) : len;
    assign start_ok = (state == IDLE) && start && !stop && (len != '0);
    assign wr_ok    = (state == IDLE) && wr_en && !start_ok && (int'(wr_addr) < STEPS);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through it can infer a latch.
        is_last   = 1'b0;
        next_addr = cur_addr + AW'(1);
        if (LW'(cur_addr) + LW'(1) == len_q) begin
            is_last   = 1'b1;
            next_addr = '0;
        end
    end

    // The step in rdata goes out on the FETCH->PLAY edge and on every gap
    // expiry, except after the final step of a one-shot run.
    assign emit   = !stop && ((state == FETCH) ||
                              ((state == PLAY) && t_expire && !final_q));
    assign finish = !stop && (state == PLAY) && t_expire && final_q;

    assign rd_en   = start_ok || emit;
    assign rd_addr = start_ok ? '0 : next_addr;
    assign t_val   = CW'(gap_ticks(rdata[1:0], GAP0, GAP1, GAP2, GAP3) - 1);

    // NOTE: the pattern memory and its read register have no reset; a
    // pattern loaded once survives a reset of the playback logic.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_addr] <= {wr_mask, wr_gap};
        end
        if (rd_en) begin
            rdata <= mem[rd_addr];
        end
    end

    step_timer #(.CW(CW)) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (emit),
        .load_val (t_val),
        .clear    (stop),
        .hold     (pause),
        .expire   (t_expire)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            spawn      <= '0;
            step_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            loop_count <= '0;
            cur_addr   <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            final_q    <= 1'b0;
        end else begin
            spawn <= '0;
            done  <= 1'b0;

            if (emit) begin
                spawn    <= rdata[DW-1:2];
                step_idx <= cur_addr;
                cur_addr <= next_addr;
                final_q  <= is_last && !loop_q;
                // Step 0 emitted from PLAY can only be a wrap.
                if ((state == PLAY) && (cur_addr == '0) && (loop_count != 8'hFF)) begin
                    loop_count <= loop_count + 8'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_ok) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        len_q      <= len_eff;
                        loop_q     <= loop_en;
                        loop_count <= '0;
                        cur_addr   <= '0;
                        final_q    <= 1'b0;
                    end
                end
                FETCH, PLAY: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (state == FETCH) begin
                        state <= PLAY;
                    end else if (finish) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through this pulse and drops in IDLE.
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_choreography_sequencer.sv
// -----------------------------------------------------------------------------
// tb_choreography_sequencer
// Scoreboard bench: each scenario queues the spawn/done events it expects,
// and a monitor on the falling edge pops and compares whenever the DUT shows
// a spawn or a done pulse. Cycle k is the interval after rising edge k.
// -----------------------------------------------------------------------------
module tb_choreography_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start, stop, pause, loop_en;
    logic [3:0] len;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_mask;
    logic [1:0] wr_gap;
    logic [3:0] spawn;
    logic [2:0] step_idx;
    logic       busy, done;
    logic [7:0] loop_count;

    choreography_sequencer #(
        .LANES(4), .STEPS(8), .GAP0(4), .GAP1(6), .GAP2(8), .GAP3(10), .CW(30)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .len(len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_gap(wr_gap), .spawn(spawn), .step_idx(step_idx),
        .busy(busy), .done(done), .loop_count(loop_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] spawn;
        logic [2:0] idx;
        logic       done;
        logic [7:0] lc;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_ev(input int c, input logic [3:0] s, input logic [2:0] i,
                             input logic d, input logic [7:0] l);
        ev_t e;
        e.cyc = c; e.spawn = s; e.idx = i; e.done = d; e.lc = l;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each observed event with the head of the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (spawn != 4'b0 || done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_spawn", spawn, 0);
                    check("unexpected_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_spawn", spawn, e.spawn);
                    check("ev_done", done, e.done);
                    check("ev_step_idx", step_idx, e.idx);
                    check("ev_loop_count", loop_count, e.lc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic write_step(input int a, input logic [3:0] m, input logic [1:0] g);
        wr_en = 1'b1; wr_addr = 3'(a); wr_mask = m; wr_gap = g;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_play(input int l, input logic lp, output int t);
        len = 4'(l); loop_en = lp; start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int until_cyc);
        wait_until(until_cyc);
        check(name, exp_q.size(), 0);
    endtask

    task automatic push_oneshot3(input int t);
        expect_ev(t + 2,  4'b0001, 3'd0, 1'b0, 8'd0);
        expect_ev(t + 6,  4'b0110, 3'd1, 1'b0, 8'd0);
        expect_ev(t + 12, 4'b1000, 3'd2, 1'b0, 8'd0);
        expect_ev(t + 21, 4'b0000, 3'd2, 1'b1, 8'd0);
    endtask

    initial begin
        int t;
        resetn = 1'b0; start = 0; stop = 0; pause = 0; loop_en = 0; len = '0;
        wr_en = 0; wr_addr = '0; wr_mask = '0; wr_gap = '0;
        tick(); tick();
        check("rst_spawn", spawn, 0);
        check("rst_step_idx", step_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_loop_count", loop_count, 0);
        resetn = 1'b1;
        tick();

        // One-shot playback of three steps.
        write_step(0, 4'b0001, 2'd0);
        write_step(1, 4'b0110, 2'd1);
        write_step(2, 4'b1000, 2'd2);
        start_play(3, 1'b0, t);
        push_oneshot3(t);
        wait_until(t + 20);
        check("oneshot_busy_before_done", busy, 1);
        wait_until(t + 22);
        check("oneshot_busy_after_done", busy, 0);
        drain("oneshot_pending", t + 24);

        // Loop mode: two wraps, then stop.
        start_play(3, 1'b1, t);
        expect_ev(t + 2,  4'b0001, 3'd0, 1'b0, 8'd0);
        expect_ev(t + 6,  4'b0110, 3'd1, 1'b0, 8'd0);
        expect_ev(t + 12, 4'b1000, 3'd2, 1'b0, 8'd0);
        expect_ev(t + 20, 4'b0001, 3'd0, 1'b0, 8'd1);
        expect_ev(t + 24, 4'b0110, 3'd1, 1'b0, 8'd1);
        expect_ev(t + 30, 4'b1000, 3'd2, 1'b0, 8'd1);
        expect_ev(t + 38, 4'b0001, 3'd0, 1'b0, 8'd2);
        expect_ev(t + 40, 4'b0000, 3'd0, 1'b1, 8'd2);
        wait_until(t + 39);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_until(t + 41);
        check("loop_busy_after_stop", busy, 0);
        drain("loop_pending", t + 50);

        // Pause for five cycles in the first (10-tick) gap.
        write_step(0, 4'b0010, 2'd3);
        write_step(1, 4'b0001, 2'd0);
        start_play(2, 1'b0, t);
        expect_ev(t + 2,  4'b0010, 3'd0, 1'b0, 8'd0);
        expect_ev(t + 17, 4'b0001, 3'd1, 1'b0, 8'd0);
        expect_ev(t + 22, 4'b0000, 3'd1, 1'b1, 8'd0);
        wait_until(t + 4);
        pause = 1'b1;
        wait_until(t + 9);
        pause = 1'b0;
        drain("pause_pending", t + 26);

        // Stop mid-play, with a write attempted while playing.
        write_step(0, 4'b0001, 2'd0);
        write_step(1, 4'b0110, 2'd1);
        write_step(2, 4'b1000, 2'd2);
        start_play(3, 1'b0, t);
        expect_ev(t + 2, 4'b0001, 3'd0, 1'b0, 8'd0);
        expect_ev(t + 6, 4'b0000, 3'd0, 1'b1, 8'd0);
        wait_until(t + 3);
        write_step(1, 4'b1111, 2'd0);
        wait_until(t + 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_until(t + 7);
        check("stop_busy", busy, 0);
        drain("stop_pending", t + 25);
        // Replay: step 1 must still be the original 0110.
        start_play(3, 1'b0, t);
        push_oneshot3(t);
        drain("replay_pending", t + 24);

        // Start with len = 0 is ignored.
        start_play(0, 1'b0, t);
        check("len0_busy_t1", busy, 0);
        wait_until(t + 4);
        check("len0_busy_t4", busy, 0);

        // len = 9 clamps to 8 steps; step 3 is a rest.
        for (int i = 0; i < 8; i++) begin
            write_step(i, (i == 3) ? 4'b0000 : 4'(i + 1), 2'd0);
        end
        start_play(9, 1'b0, t);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) expect_ev(t + 2 + 4 * i, 4'(i + 1), 3'(i), 1'b0, 8'd0);
        end
        expect_ev(t + 35, 4'b0000, 3'd7, 1'b1, 8'd0);
        drain("clamp_pending", t + 45);
        check("clamp_busy_end", busy, 0);

        // Reset mid-play, then the retained pattern replays identically.
        start_play(2, 1'b0, t);
        expect_ev(t + 2, 4'b0001, 3'd0, 1'b0, 8'd0);
        expect_ev(t + 6, 4'b0010, 3'd1, 1'b0, 8'd0);
        wait_until(t + 7);
        resetn = 1'b0;
        tick();
        check("midrst_spawn", spawn, 0);
        check("midrst_step_idx", step_idx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_loop_count", loop_count, 0);
        resetn = 1'b1;
        drain("midrst_pending", t + 12);
        start_play(2, 1'b0, t);
        expect_ev(t + 2,  4'b0001, 3'd0, 1'b0, 8'd0);
        expect_ev(t + 6,  4'b0010, 3'd1, 1'b0, 8'd0);
        expect_ev(t + 11, 4'b0000, 3'd1, 1'b1, 8'd0);
        drain("midrst_replay_pending", t + 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/choreography_sequencer.md
Name: choreography_sequencer

Overview:
- Parametrised successor of the fixed-pattern block-drop generator.
- Plays a loadable step pattern.
- Each step carries an N-lane spawn mask (rests and chords allowed) and a 2-bit gap code that selects the tick delay to the next step from a parameter tempo table.
- Adds:
  - runtime pattern load,
  - variable length,
  - one-shot or loop mode,
  - pause/stop,
  - status outputs.
- Drives the lane block-spawn logic of the game datapath.

Parameters:
- LANES, 4, number of note lanes (spawn mask width).
- STEPS, 128, pattern memory depth.
- GAP0, 10000000, ticks for gap code 0.
- GAP1, 6000000, ticks for gap code 1.
- GAP2, 20000000, ticks for gap code 2.
- GAP3, 9000000, ticks for gap code 3.
- CW, 30, gap counter width.
- Derived: AW = $clog2(STEPS); LW = $clog2(STEPS+1).

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  begin playback (accepted in IDLE only)
- stop  in  1  abort playback
- pause  in  1  level; freezes playback while high
- loop_en  in  1  sampled at start; 1 = wrap to step 0 after the last step
- len  in  LW  pattern length, sampled at start
- wr_en  in  1  pattern write strobe (honoured in IDLE only)
- wr_addr  in  AW  step address
- wr_mask  in  LANES  lane mask for the step
- wr_gap  in  2  gap code for the step
- spawn  out  LANES  one-cycle lane spawn pulses
- step_idx  out  AW  index of the last emitted step
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at one-shot completion or on stop
- loop_count  out  8  completed loops, saturating at 255

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clock.
- Reset values:
  - FSM = IDLE.
  - spawn, step_idx, busy, done, loop_count = 0.
  - gap counter cleared.
  - Pattern memory is NOT cleared.
- Memory: STEPS x (LANES+2) bits, synchronous read with 1-cycle latency.
- Write rules:
  - A write with wr_en high in IDLE lands the next cycle.
  - wr_en outside IDLE is ignored.
  - wr_addr >= STEPS is ignored.
- States: IDLE, FETCH, PLAY, DONE.
- IDLE:
  - start with len == 0: ignored.
  - start with len > STEPS: len is clamped to STEPS.
  - Otherwise: latch len and loop_en, clear loop_count, issue read of addr 0, go to FETCH.
  - A simultaneous wr_en in the same cycle is ignored.
- FETCH (1 cycle): read data becomes valid; go to PLAY with the emit flag set.
- PLAY emit cycle:
  - spawn = mask; step_idx = addr.
  - Counter loaded with GAPn-1 for the step's gap code.
  - Read of the next address issued. The next address is addr+1, or 0 when addr == len-1 and loop_en is set.
- Timing:
  - First spawn occurs 2 cycles after the start cycle.
  - Each subsequent spawn occurs exactly GAPn cycles after the previous one while unpaused (GAPn >= 2 is required).
  - The next step's data is held in a register until emitted.
- Last step:
  - When the last step's gap expires with loop_en = 0: no spawn; go to DONE.
  - With loop_en = 1: step 0 is emitted at that cycle and loop_count increments (saturating).
- Rest step: mask = 0 gives spawn = 0, but timing proceeds normally.
- Pause:
  - While pause is high in PLAY, the counter holds and no spawn is emitted.
  - After release, the remaining count resumes.
  - If pause is high on the cycle an emit would occur, the emit is deferred to the first unpaused cycle.
  - Pause in IDLE/FETCH/DONE has no effect.
- Stop:
  - From FETCH or PLAY: next cycle = IDLE, done pulses once, spawn = 0.
  - stop has priority over pause and emit.
  - stop and start together in IDLE: stop wins and start is ignored.
- DONE (1 cycle): done = 1; go to IDLE. busy is low from that IDLE onward.
- Reset mid-playback: immediately IDLE with outputs at reset values. Memory contents are retained.

Decomposition:
- Package choreo_pkg holds:
  - state enum {IDLE, FETCH, PLAY, DONE},
  - gap code typedef (2 bits),
  - the gap-to-ticks lookup function using GAP0..GAP3.
- Sub-module step_timer: loadable down-counter with hold (pause) and an expire pulse. The top level holds the FSM, memory, and address logic.

Test Plan:
- Test parameters for all scenarios: LANES=4, STEPS=8, GAP0..3 = 4, 6, 8, 10.
- One-shot playback:
  - Stimulus: load steps 0..2 = {0001,g0}, {0110,g1}, {1000,g2}; len=3; loop_en=0; start at cycle T.
  - Expected: spawn 0001 at T+2, 0110 at T+6, 1000 at T+12; done at T+21; busy low from T+22.
- Loop mode:
  - Stimulus: same pattern with loop_en=1.
  - Expected: step 0 re-emits at T+20; loop_count = 1; a second wrap at T+38 gives loop_count = 2.
- Pause:
  - Stimulus: single step {0010,g3}, len=2 (step 1 = {0001,g0}); pause high for 5 cycles beginning at T+4.
  - Expected: second spawn at T+17 instead of T+12.
- Stop and write lockout:
  - Stimulus: assert stop at T+5 during playback.
  - Expected: done pulses at T+6, no further spawns, busy low.
  - Stimulus: wr_en during PLAY.
  - Expected: memory unchanged, confirmed by replay.
- Boundaries:
  - Stimulus: start with len=0.
  - Expected: stays IDLE, busy = 0.
  - Stimulus: len=9.
  - Expected: clamps to 8 steps.
  - Stimulus: rest step mask=0000.
  - Expected: no spawn, but the next step keeps its timing.
- Reset mid-play:
  - Stimulus: resetn low at T+7 for 1 cycle, then start again.
  - Expected: all outputs 0 during reset; the old pattern replays identically.
